deco_seq_n: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder for the 19-bit CPU, the successor of the combinational 3-to-8 decoder. It adds a valid/ready input handshake, a registered output with `out_valid`, and three modes: latched DIRECT decode, single-cycle PULSE strobes, and autonomous SCAN sequencing. It drives register-file write enables, peripheral selects and scan strobes from control logic.

---
 rtl/deco_pkg.sv | 22 ++
 rtl/onehot_dec.sv | 16 +
 rtl/deco_seq_n.sv | 104 ++++++++++
 tb/tb_deco_seq_n.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/deco_pkg.sv
// Shared mode encodings, FSM state type and one-hot helper for the sequenced decoder.
package deco_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_SCAN   = 2'd2;
  localparam logic [1:0] MODE_IDLE   = 2'd3;

  // State encodings match the mode encodings so the next state is the mode itself.
  typedef enum logic [1:0] {
    ST_DIRECT = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SCAN   = 2'd2,
    ST_IDLE   = 2'd3
  } state_t;

  // Widest supported select is 8 bits; callers truncate to their OUT_W.
  function automatic logic [255:0] onehot(input logic [7:0] sel);
    onehot = 256'd1 << sel;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Pure combinational SEL_W-to-2^SEL_W one-hot decoder.
// Latency 0; no handshake, no state.
// No backpressure: output follows idx directly.
module onehot_dec
  import deco_pkg::*;
#(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  output logic [OUT_W-1:0] dec
);

  assign dec = OUT_W'(onehot(8'(idx)));

endmodule

// File: rtl/deco_seq_n.sv
// Registered N-to-2^N one-hot decoder with DIRECT latch, PULSE strobe and SCAN sequencing.
// Latency 1 cycle from accept (or scan step) to decoded_op.
// in_ready drops outside DIRECT/PULSE, on mode change and when en is low.
module deco_seq_n
  import deco_pkg::*;
#(
  parameter  int SEL_W      = 3,
  parameter  bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W      = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [SEL_W-1:0] select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] decoded_op,
  output logic             out_valid,
  output logic [SEL_W-1:0] scan_idx,
  output logic             scan_wrap
);

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic             held;
  logic [SEL_W-1:0] cnt;
  logic [OUT_W-1:0] dec_q;
  logic [OUT_W-1:0] dec_nxt;
  logic [SEL_W-1:0] idx_mux;
  logic             mode_chg;
  logic             accept;

  assign mode_chg = (mode != 2'(state));
  assign in_ready = en && !rst && (mode == MODE_DIRECT || mode == MODE_PULSE) && !mode_chg;
  assign accept   = in_valid && in_ready;

  // A fresh accept decodes the incoming select; otherwise the held code or the scan counter.
  assign idx_mux = accept ? select : ((state == ST_SCAN) ? cnt : sel_q);

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx (idx_mux),
    .dec (dec_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      held      <= 1'b0;
      cnt       <= '0;
      dec_q     <= '0;
      out_valid <= 1'b0;
      scan_idx  <= '0;
      scan_wrap <= 1'b0;
    end else if (mode_chg) begin
      state     <= state_t'(mode);
      held      <= 1'b0;
      cnt       <= '0;
      dec_q     <= '0;
      out_valid <= 1'b0;
      scan_idx  <= '0;
      scan_wrap <= 1'b0;
    end else begin
      dec_q     <= '0;
      out_valid <= 1'b0;
      scan_idx  <= '0;
      scan_wrap <= 1'b0;
      if (en) begin
        case (state)
          ST_DIRECT: begin
            if (accept) begin
              sel_q     <= select;
              held      <= 1'b1;
              dec_q     <= dec_nxt;
              out_valid <= 1'b1;
            end else if (held) begin
              dec_q     <= dec_nxt;
              out_valid <= 1'b1;
            end
          end
          ST_PULSE: begin
            if (accept) begin
              dec_q     <= dec_nxt;
              out_valid <= 1'b1;
            end
          end
          ST_SCAN: begin
            dec_q     <= dec_nxt;
            out_valid <= 1'b1;
            scan_idx  <= cnt;
            scan_wrap <= (cnt == SEL_W'(OUT_W - 1));
            cnt       <= cnt + SEL_W'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign decoded_op = ACTIVE_LOW ? ~dec_q : dec_q;

endmodule

// File: tb/tb_deco_seq_n.sv
// Directed self-checking bench for deco_seq_n: default, ACTIVE_LOW and SEL_W=4 instances.
module tb_deco_seq_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        en;
  logic [2:0]  select;
  logic        in_valid;
  logic        sel4_ovr;
  logic [3:0]  sel4_val;
  logic [3:0]  sel4;

  logic        rdy, ov, wrap;
  logic [7:0]  dec;
  logic [2:0]  sidx;
  logic        rdy_al, ov_al, wrap_al;
  logic [7:0]  dec_al;
  logic [2:0]  sidx_al;
  logic        rdy4, ov4, wrap4;
  logic [15:0] dec4;
  logic [3:0]  sidx4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign sel4 = sel4_ovr ? sel4_val : {1'b0, select};

  deco_seq_n #(.SEL_W(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .select(select), .in_valid(in_valid),
    .in_ready(rdy), .decoded_op(dec), .out_valid(ov), .scan_idx(sidx), .scan_wrap(wrap)
  );

  deco_seq_n #(.SEL_W(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .select(select), .in_valid(in_valid),
    .in_ready(rdy_al), .decoded_op(dec_al), .out_valid(ov_al), .scan_idx(sidx_al),
    .scan_wrap(wrap_al)
  );

  deco_seq_n #(.SEL_W(4), .ACTIVE_LOW(1'b0)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .select(sel4), .in_valid(in_valid),
    .in_ready(rdy4), .decoded_op(dec4), .out_valid(ov4), .scan_idx(sidx4), .scan_wrap(wrap4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the 8-bit instance and its active-low twin together.
  task automatic chk8(input string tag, input logic [7:0] e, input logic ev);
    logic [7:0] e_n;
    e_n = ~e;
    chk({tag, " dec"}, 32'(dec), 32'(e));
    chk({tag, " ov"}, 32'(ov), 32'(ev));
    chk({tag, " dec_al"}, 32'(dec_al), 32'(e_n));
  endtask

  logic [7:0] exp_oh [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    rst = 1'b1; mode = 2'd0; en = 1'b1; select = 3'd0; in_valid = 1'b0;
    sel4_ovr = 1'b0; sel4_val = 4'd0;

    // Reset
    step(); step();
    chk8("reset", 8'h00, 1'b0);
    chk("reset in_ready", 32'(rdy), 32'(0));
    chk("reset scan_idx", 32'(sidx), 32'(0));
    chk("reset scan_wrap", 32'(wrap), 32'(0));
    chk("reset dec4", 32'(dec4), 32'h0000);

    // Leave reset: first edge moves IDLE -> DIRECT
    rst = 1'b0;
    step();
    chk("direct in_ready", 32'(rdy), 32'(1));
    chk8("direct entry", 8'h00, 1'b0);

    // DIRECT sweep, one accept per cycle
    for (int i = 0; i < 8; i++) begin
      select = 3'(i); in_valid = 1'b1;
      step();
      chk8("direct sweep", exp_oh[i], 1'b1);
      chk("direct sweep dec4", 32'(dec4), 32'(16'd1 << i));
    end
    in_valid = 1'b0;
    step();
    chk8("direct hold1", 8'h80, 1'b1);
    step();
    chk8("direct hold2", 8'h80, 1'b1);

    // Mode change DIRECT(0x10) -> PULSE with in_valid high
    select = 3'd4; in_valid = 1'b1;
    step();
    chk8("direct 0x10", 8'h10, 1'b1);
    mode = 2'd1; select = 3'd6;
    #1;
    chk("modechg in_ready", 32'(rdy), 32'(0));
    step();
    chk8("modechg out", 8'h00, 1'b0);
    in_valid = 1'b0;

    // PULSE: single strobe then back-to-back
    select = 3'd5; in_valid = 1'b1;
    step();
    chk8("pulse 5", 8'h20, 1'b1);
    in_valid = 1'b0;
    step();
    chk8("pulse 5 off", 8'h00, 1'b0);
    select = 3'd2; in_valid = 1'b1;
    step();
    chk8("pulse 2", 8'h04, 1'b1);
    select = 3'd3;
    step();
    chk8("pulse 3", 8'h08, 1'b1);
    in_valid = 1'b0;
    step();
    chk8("pulse end", 8'h00, 1'b0);

    // DIRECT hold across en low; en falling with in_valid is not an accept
    mode = 2'd0;
    step();
    select = 3'd1; in_valid = 1'b1;
    step();
    chk8("direct 0x02", 8'h02, 1'b1);
    select = 3'd7; en = 1'b0;
    #1;
    chk("en low in_ready", 32'(rdy), 32'(0));
    step();
    chk8("en low 1", 8'h00, 1'b0);
    in_valid = 1'b0;
    step();
    chk8("en low 2", 8'h00, 1'b0);
    en = 1'b1;
    step();
    chk8("en back held", 8'h02, 1'b1);

    // SCAN: mode-change cycle, then two full periods
    mode = 2'd2;
    step();
    chk8("scan entry", 8'h00, 1'b0);
    chk("scan in_ready", 32'(rdy), 32'(0));
    for (int k = 0; k < 16; k++) begin
      step();
      chk8("scan seq", exp_oh[k % 8], 1'b1);
      chk("scan idx", 32'(sidx), 32'(k % 8));
      chk("scan wrap", 32'(wrap), 32'((k % 8) == 7));
    end
    step(); step(); step();
    chk8("scan cnt3", 8'h04, 1'b1);
    en = 1'b0;
    step();
    chk8("scan pause1", 8'h00, 1'b0);
    step();
    chk8("scan pause2", 8'h00, 1'b0);
    chk("scan pause idx", 32'(sidx), 32'(0));
    en = 1'b1;
    step();
    chk8("scan resume", 8'h08, 1'b1);
    chk("scan resume idx", 32'(sidx), 32'(3));

    // Reset mid-scan discards the counter
    rst = 1'b1;
    step();
    chk8("midrst", 8'h00, 1'b0);
    chk("midrst idx", 32'(sidx), 32'(0));
    rst = 1'b0;
    step();
    chk8("midrst reentry", 8'h00, 1'b0);
    step();
    chk8("midrst restart", 8'h01, 1'b1);

    // IDLE
    mode = 2'd3;
    step(); step();
    chk8("idle", 8'h00, 1'b0);
    chk("idle in_ready", 32'(rdy), 32'(0));

    // SEL_W=4: select 15 in DIRECT, then a 16-cycle scan period
    mode = 2'd0;
    step();
    sel4_ovr = 1'b1; sel4_val = 4'd15; in_valid = 1'b1;
    step();
    chk("w4 direct 15", 32'(dec4), 32'h8000);
    chk("w4 ov", 32'(ov4), 32'(1));
    in_valid = 1'b0;
    mode = 2'd2;
    step();
    for (int k = 0; k < 32; k++) begin
      step();
      chk("w4 scan", 32'(dec4), 32'(16'd1 << (k % 16)));
      chk("w4 wrap", 32'(wrap4), 32'((k % 16) == 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
